// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler sharing one 4-to-1 mux between four requesters.
// The winner's word is captured into an output register and held under a
// valid/ready handshake. The grant is acknowledged in the cycle the consumer
// accepts the word.
module mux4_rr_scheduler #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              sel1,
  output logic              sel2,
  output logic [3:0]        gnt,
  output logic [3:0]        ack
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;
  logic [3:0]        gnt_q, gnt_d;

  logic              accept;
  logic [1:0]        arb_ptr;
  logic [3:0]        arb_req;
  logic [2:0]        pick;

  // Returns {found, index}. Scans ptr, ptr+1, ptr+2, ptr+3 (mod 4) and
  // reports the first source with its request bit set. The loop runs from
  // the farthest offset down to the nearest, so the nearest offset is
  // written last and wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Shared 4-to-1 data mux. The select encoding matches {sel1, sel2}.
  function automatic logic [DATA_W-1:0] mux4(input logic [1:0] s,
                                             input logic [DATA_W-1:0] a0,
                                             input logic [DATA_W-1:0] a1,
                                             input logic [DATA_W-1:0] a2,
                                             input logic [DATA_W-1:0] a3);
    case (s)
      2'd0:    mux4 = a0;
      2'd1:    mux4 = a1;
      2'd2:    mux4 = a2;
      default: mux4 = a3;
    endcase
  endfunction

  // Next-state logic: arbitrate in IDLE, or re-arbitrate on accept.
  // On accept the pointer advances past the acked source, and that source's
  // request is masked for this cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    gnt_d   = gnt_q;

    accept  = (state_q == HOLD) && out_ready;
    arb_ptr = accept ? (src_q + 2'd1) : ptr_q;
    arb_req = accept ? (req & ~gnt_q) : req;
    pick    = rr_pick(arb_req, arb_ptr);

    if (state_q == IDLE || accept) begin
      if (accept) ptr_d = arb_ptr;
      if (pick[2]) begin
        state_d = HOLD;
        src_d   = pick[1:0];
        data_d  = mux4(pick[1:0], din0, din1, din2, din3);
        gnt_d   = 4'b0001 << pick[1:0];
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    end
  end

  // State and output registers. Reset clears all of them, including the
  // held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      src_q   <= 2'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign sel1      = src_q[1];
  assign sel2      = src_q[0];
  assign gnt       = gnt_q;
  assign ack       = gnt_q & {4{out_valid & out_ready}};

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_mux4_rr_scheduler;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] din_a [4];
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          sel1, sel2;
  logic [3:0]    gnt, ack;

  int tests_run = 0;
  int failed    = 0;

  // Reference model state.
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_ptr;

  mux4_rr_scheduler #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .din0(din_a[0]), .din1(din_a[1]), .din2(din_a[2]), .din3(din_a[3]),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .sel1(sel1), .sel2(sel2), .gnt(gnt), .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    return m_valid ? 4'(1 << m_src) : 4'b0000;
  endfunction

  function automatic logic [3:0] m_ack();
    return (m_valid && out_ready) ? 4'(1 << m_src) : 4'b0000;
  endfunction

  function automatic logic [20:0] exp_vec();
    logic [1:0] s;
    s = 2'(m_src);
    return {m_valid, m_data, s, s[1], s[0], m_gnt(), m_ack()};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {out_valid, out_data, out_src, sel1, sel2, gnt, ack};
  endfunction

  // Applies the scheduling rules for one clock edge.
  task automatic model_edge();
    int w;
    logic [3:0] r;
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (!m_valid) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_valid = 1; m_src = w; m_data = din_a[w];
      end
    end else if (out_ready) begin
      m_ptr = (m_src + 1) % 4;
      r = req & ~4'(1 << m_src);
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_src = w; m_data = din_a[w];
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req = 4'b1111; out_ready = 1;
    for (int i = 0; i < 4; i++) din_a[i] = 8'hFF;
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (obs_vec() !== 21'd0) begin
        failed++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", c, obs_vec());
      end
      tick();
    end
    req = 4'b0000;
    tick();
    rst = 0;
  endtask

  task automatic test_single();
    req = 4'b0100; din_a[2] = 8'hA5; out_ready = 1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL single_idle got=%b exp=0", out_valid);
    end
    tick(); #1;
    tests_run++;
    if ({out_valid, out_data, sel1, sel2, gnt, ack} !== {1'b1, 8'hA5, 2'b10, 4'b0100, 4'b0100}) begin
      failed++;
      $display("FAIL single_grant got v=%b d=%h sel=%b%b g=%b a=%b exp v=1 d=a5 sel=10 g=0100 a=0100",
               out_valid, out_data, sel1, sel2, gnt, ack);
    end
    tick(); #1;
    tests_run++;
    if (ack !== 4'b0000 || out_valid !== 1'b0) begin
      failed++; $display("FAIL single_after got v=%b a=%b exp v=0 a=0000", out_valid, ack);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_rotation();
    int exp_src [6] = '{0, 1, 2, 3, 0, 1};
    rst = 1; req = 4'b0000; tick(); rst = 0;
    req = 4'b1111; out_ready = 1;
    for (int i = 0; i < 4; i++) din_a[i] = 8'(i);
    tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      tests_run++;
      if (out_src !== 2'(exp_src[k]) || out_valid !== 1'b1 || ack !== 4'(1 << exp_src[k])
          || out_data !== 8'(exp_src[k])) begin
        failed++;
        $display("FAIL rotation k=%0d got src=%0d v=%b a=%b d=%h exp src=%0d v=1", k, out_src,
                 out_valid, ack, out_data, exp_src[k]);
      end
      tick();
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    req = 4'b0010; din_a[1] = 8'h3C; out_ready = 0;
    tick();
    for (int c = 0; c < 5; c++) begin
      req = 4'($urandom); din_a[1] = 8'($urandom);
      #1;
      tests_run++;
      if (out_data !== 8'h3C || gnt !== 4'b0010 || ack !== 4'b0000 || out_valid !== 1'b1) begin
        failed++;
        $display("FAIL backpressure c=%0d got d=%h g=%b a=%b v=%b exp d=3c g=0010 a=0000 v=1",
                 c, out_data, gnt, ack, out_valid);
      end
      tick();
    end
    req = 4'b0010; out_ready = 1;
    #1;
    tests_run++;
    if (ack !== 4'b0010) begin
      failed++; $display("FAIL bp_release got a=%b exp a=0010", ack);
    end
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_ptr_mask();
    req = 4'b1000; out_ready = 1;
    for (int i = 0; i < 4; i++) din_a[i] = 8'h10 + 8'(i);
    tick();
    req = 4'b1001;
    #1;
    tests_run++;
    if (out_src !== 2'd3 || ack !== 4'b1000) begin
      failed++; $display("FAIL ptr_src3 got src=%0d a=%b exp src=3 a=1000", out_src, ack);
    end
    tick(); #1;
    tests_run++;
    if (out_src !== 2'd0 || out_valid !== 1'b1) begin
      failed++; $display("FAIL ptr_src0 got src=%0d v=%b exp src=0 v=1", out_src, out_valid);
    end
    req = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      tick(); #1;
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL ptr_lone c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0100; out_ready = 0;
    tick();
    rst = 1;
    #1;
    tests_run++;
    if (ack !== 4'b0000 || out_valid !== 1'b1) begin
      failed++; $display("FAIL rstmid_pre got a=%b v=%b exp a=0000 v=1", ack, out_valid);
    end
    tick();
    rst = 0; req = 4'b1111;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || ack !== 4'b0000) begin
      failed++; $display("FAIL rstmid_post got v=%b a=%b exp v=0 a=0000", out_valid, ack);
    end
    tick(); #1;
    tests_run++;
    if (out_src !== 2'd0 || gnt !== 4'b0001) begin
      failed++; $display("FAIL rstmid_first got src=%0d g=%b exp src=0 g=0001", out_src, gnt);
    end
    req = 4'b0000; out_ready = 1;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req       = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) din_a[i] = 8'($urandom);
      #1;
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; req = 4'b0000; out_ready = 0;
    for (int i = 0; i < 4; i++) din_a[i] = '0;
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_ptr_mask();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
